cache_wb_buffer: RTL

CACHE_WB_BUFFER -- requirements
Module: cache_wb_buffer

---
 rtl/cache_wb_buffer_if.sv | 29 ++
 rtl/cache_wb_buffer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cache_wb_buffer_if.sv
// rtl/cache_wb_buffer_if.sv - write-back buffer bus bundle: eviction push, fill lookup, RAM write port
interface cache_wb_buffer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ready;

    logic              lk_valid;
    logic [ADDR_W-1:0] lk_addr;
    logic              lk_hit;
    logic [DATA_W-1:0] lk_data;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;

    modport master (
        output wb_valid, wb_addr, wb_data, lk_valid, lk_addr,
        input  wb_ready, lk_hit, lk_data, ram_addr, ram_data, ram_wren
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, lk_valid, lk_addr,
        output wb_ready, lk_hit, lk_data, ram_addr, ram_data, ram_wren
    );
endinterface

// File: rtl/cache_wb_buffer.sv
// rtl/cache_wb_buffer.sv - 4-entry coalescing write-back buffer with miss-fill forwarding
module cache_wb_buffer (
    input  logic               clk_i,
    input  logic               rst_ni,
    cache_wb_buffer_if.slave   bus,
    output logic [2:0]         count_o,
    output logic               busy_o
);
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [1:0]        head_q, head_d;
    logic [1:0]        tail_q, tail_d;
    logic [2:0]        count_q, count_d;

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              ram_wren_q, ram_wren_d;
    logic              lk_hit_q, lk_hit_d;
    logic [DATA_W-1:0] lk_data_q, lk_data_d;

    logic              wb_ready;
    logic              push_ok;
    logic              co_hit;
    logic [1:0]        co_idx;
    logic              alloc;
    logic              pop;
    logic [1:0]        lk_idx;

    assign wb_ready     = (count_q < 3'd4);
    assign bus.wb_ready = wb_ready;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_data = ram_data_q;
    assign bus.ram_wren = ram_wren_q;
    assign bus.lk_hit   = lk_hit_q;
    assign bus.lk_data  = lk_data_q;
    assign count_o      = count_q;
    assign busy_o       = (count_q != 3'd0) || (state_q == S_WRITE);

    // Drain FSM: load the head into the RAM port, then retire it one cycle later.
    always_comb begin
        state_d    = state_q;
        ram_wren_d = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != 3'd0) begin
                    ram_wren_d = 1'b1;
                    ram_addr_d = addr_q[head_q];
                    ram_data_d = data_q[head_q];
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                pop     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The head is excluded from coalescing because it may already be latched into the RAM port.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        push_ok = bus.wb_valid && wb_ready;
        co_hit  = 1'b0;
        co_idx  = 2'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == bus.wb_addr) && (2'(i) != head_q)) begin
                co_hit = 1'b1;
                co_idx = 2'(i);
            end
        end
        alloc = push_ok && !co_hit;

        if (push_ok && co_hit) begin
            data_d[co_idx] = bus.wb_data;
        end
        if (alloc) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = bus.wb_addr;
            data_d[tail_q]  = bus.wb_data;
            tail_d          = tail_q + 2'd1;
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 2'd1;
        end
        count_d = count_q + {2'b00, alloc} - {2'b00, pop};
    end

    // Walk oldest to youngest so the last match wins; pre-edge contents only.
    always_comb begin
        lk_hit_d  = 1'b0;
        lk_data_d = '0;
        lk_idx    = 2'd0;
        if (bus.lk_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                lk_idx = head_q + 2'(i);
                if (valid_q[lk_idx] && (addr_q[lk_idx] == bus.lk_addr)) begin
                    lk_hit_d  = 1'b1;
                    lk_data_d = data_q[lk_idx];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_wren_q <= 1'b0;
            lk_hit_q   <= 1'b0;
            lk_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_wren_q <= ram_wren_d;
            lk_hit_q   <= lk_hit_d;
            lk_data_q  <= lk_data_d;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end
endmodule
